// File: rtl/prog_dumper_pkg.sv
// Shared definitions for the program loader / dumper pair: FSM state
// encodings and the default external memory address width.
package prog_dumper_pkg;

  localparam int DM_ADR_WIDTH = 21;
  localparam int DM_LAT_WIDTH = 3;

  typedef enum logic [2:0] {
    DM_IDLE = 3'd0,
    DM_ADR  = 3'd1,
    DM_READ = 3'd2,
    DM_WAIT = 3'd3,
    DM_ACK  = 3'd4,
    DM_INC  = 3'd5
  } dm_state_e;

endpackage

// File: rtl/prog_dumper_seq_handshake_tx.sv
// Toggle-sequence byte producer: holds the offered byte and a sequence bit
// that flips once per new byte. A byte is outstanding while the consumer's
// echoed sequence bit differs from ours.
module seq_handshake_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_i,
  input  logic [7:0] data_i,
  input  logic       ack_seq_i,
  output logic [7:0] data_o,
  output logic       seq_o,
  output logic       pending_o
);

  logic [7:0] data_q;
  logic       seq_q;

  // Load a new byte and flip the sequence bit in the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 8'h00;
      seq_q  <= 1'b0;
    end else if (send_i) begin
      data_q <= data_i;
      seq_q  <= ~seq_q;
    end else begin
      data_q <= data_q;
      seq_q  <= seq_q;
    end
  end

  assign data_o    = data_q;
  assign seq_o     = seq_q;
  assign pending_o = seq_q ^ ack_seq_i;

endmodule

// File: rtl/prog_dumper.sv
// Memory read-back engine: walks len bytes from start_adr, one read strobe
// per address, and hands every byte to the UART transmitter through the
// toggle-sequence handshake. Ports keep the bus-level names shared with the
// program loader.
module prog_dumper
  import prog_dumper_pkg::*;
#(
  parameter int ADR_WIDTH = DM_ADR_WIDTH,
  parameter int RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADR_WIDTH-1:0] start_adr,
  input  logic [ADR_WIDTH-1:0] len,
  input  logic                 abort,
  output logic [ADR_WIDTH-1:0] adr,
  output logic                 read,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_tx,
  output logic                 data_tx_seq,
  input  logic                 tx_ack_seq,
  output logic                 busy,
  output logic                 done
);

  // Last value of the latency counter; the capture happens on the edge that
  // closes the RD_LAT-th cycle after the read strobe.
  localparam logic [DM_LAT_WIDTH-1:0] LAT_LAST = DM_LAT_WIDTH'(RD_LAT - 1);
  localparam logic [ADR_WIDTH-1:0]    ADR_ONE  = ADR_WIDTH'(1);

  dm_state_e                state_q;
  logic [ADR_WIDTH-1:0]     adr_q;
  logic [ADR_WIDTH-1:0]     rem_q;
  logic [DM_LAT_WIDTH-1:0]  lat_q;
  logic                     read_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     abort_q;
  logic                     send_s;
  logic                     pending_s;

  assign send_s = (state_q == DM_WAIT) && (lat_q == LAT_LAST);

  seq_handshake_tx u_tx (
    .clk       (clk),
    .rst_n     (reset),
    .send_i    (send_s),
    .data_i    (data_in),
    .ack_seq_i (tx_ack_seq),
    .data_o    (data_tx),
    .seq_o     (data_tx_seq),
    .pending_o (pending_s)
  );

  // Dump sequencer: state, address walk, byte count, strobes and status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DM_IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      read_q <= 1'b0;
      done_q <= 1'b0;
      // abort is remembered until the current byte finishes in INC
      if (abort && (state_q != DM_IDLE)) begin
        abort_q <= 1'b1;
      end
      case (state_q)
        DM_IDLE: begin
          // done_q high means this is the done cycle, where start is ignored
          if (start && !done_q) begin
            if (len != '0) begin
              adr_q   <= start_adr;
              rem_q   <= len;
              busy_q  <= 1'b1;
              abort_q <= 1'b0;
              state_q <= DM_ADR;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        DM_ADR: begin
          read_q  <= 1'b1;
          state_q <= DM_READ;
        end
        DM_READ: begin
          lat_q   <= '0;
          state_q <= DM_WAIT;
        end
        DM_WAIT: begin
          if (lat_q == LAT_LAST) begin
            state_q <= DM_ACK;
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        DM_ACK: begin
          if (!pending_s) begin
            state_q <= DM_INC;
          end
        end
        DM_INC: begin
          adr_q   <= adr_q + ADR_ONE;
          rem_q   <= rem_q - ADR_ONE;
          abort_q <= 1'b0;
          if ((rem_q == ADR_ONE) || abort_q || abort) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DM_IDLE;
          end else begin
            state_q <= DM_ADR;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= DM_IDLE;
        end
      endcase
    end
  end

  assign adr  = adr_q;
  assign read = read_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_prog_dumper.sv
// Self-checking bench for prog_dumper: three instances (RD_LAT 2, 1, 7)
// share one clock; a table of dump requests is replayed against them,
// followed by hand-written abort and async-reset sequences.
module tb_prog_dumper;

  localparam int NI = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 7);
  endfunction

  logic        clk;
  logic        rst_n;
  logic        start_s   [NI];
  logic        abort_s   [NI];
  logic [20:0] sadr_s    [NI];
  logic [20:0] len_s     [NI];
  logic [20:0] adr_s     [NI];
  logic        read_s    [NI];
  logic [7:0]  din_s     [NI];
  logic [7:0]  dtx_s     [NI];
  logic        seq_s     [NI];
  logic        ack_s     [NI];
  logic        busy_s    [NI];
  logic        done_s    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    prog_dumper #(.ADR_WIDTH(21), .RD_LAT(lat_of(g))) u_dut (
      .clk         (clk),
      .reset       (rst_n),
      .start       (start_s[g]),
      .start_adr   (sadr_s[g]),
      .len         (len_s[g]),
      .abort       (abort_s[g]),
      .adr         (adr_s[g]),
      .read        (read_s[g]),
      .data_in     (din_s[g]),
      .data_tx     (dtx_s[g]),
      .data_tx_seq (seq_s[g]),
      .tx_ack_seq  (ack_s[g]),
      .busy        (busy_s[g]),
      .done        (done_s[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory and monitor state
  logic [7:0]  mem      [256];
  int          ack_dly  [NI];
  int          rd_cnt   [NI];
  int          tx_cnt   [NI];
  int          done_cnt [NI];
  int          busy_cnt [NI];
  logic [20:0] rd_log   [NI][64];
  logic [7:0]  tx_log   [NI][64];
  int          wcnt     [NI];
  int          lat_n    [NI];
  logic        lat_act  [NI];
  logic [20:0] pend_adr [NI];
  logic        prev_seq [NI];
  logic [7:0]  prev_tx  [NI];
  int          viol_cnt;
  int          glitch_cnt;
  int          n_checks;
  int          n_errors;

  // Memory, transmitter and protocol monitor, evaluated away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        ack_s[i]    = 1'b0;
        wcnt[i]     = 0;
        prev_seq[i] = 1'b0;
        prev_tx[i]  = 8'h00;
        lat_act[i]  = 1'b0;
        din_s[i]    = 8'hEE;
      end else begin
        if (lat_act[i]) begin
          lat_n[i] = lat_n[i] + 1;
          if (lat_n[i] == lat_of(i)) begin
            din_s[i]   = mem[pend_adr[i][7:0]];
            lat_act[i] = 1'b0;
          end else begin
            din_s[i] = 8'hEE;
          end
        end else begin
          din_s[i] = 8'hEE;
        end
        if (read_s[i]) begin
          if (seq_s[i] != ack_s[i]) viol_cnt = viol_cnt + 1;
          rd_log[i][rd_cnt[i] % 64] = adr_s[i];
          rd_cnt[i]   = rd_cnt[i] + 1;
          lat_act[i]  = 1'b1;
          lat_n[i]    = 0;
          pend_adr[i] = adr_s[i];
        end
        if (seq_s[i] != prev_seq[i]) begin
          if (prev_seq[i] != ack_s[i]) viol_cnt = viol_cnt + 1;
          tx_log[i][tx_cnt[i] % 64] = dtx_s[i];
          tx_cnt[i] = tx_cnt[i] + 1;
        end else if (dtx_s[i] != prev_tx[i]) begin
          glitch_cnt = glitch_cnt + 1;
        end
        prev_seq[i] = seq_s[i];
        prev_tx[i]  = dtx_s[i];
        if (done_s[i]) done_cnt[i] = done_cnt[i] + 1;
        if (busy_s[i]) busy_cnt[i] = busy_cnt[i] + 1;
        if (seq_s[i] != ack_s[i]) begin
          wcnt[i] = wcnt[i] + 1;
          if (wcnt[i] >= ack_dly[i]) begin
            ack_s[i] = seq_s[i];
            wcnt[i]  = 0;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string          nm;
    int             inst;
    logic [20:0]    sadr;
    logic [20:0]    len;
    int             ack;
    int             n;
    logic [2:0][20:0] adr;
    logic [2:0][7:0]  b;
    logic [20:0]    end_adr;
    logic           seq;
    int             cyc;
  } vec_t;

  vec_t vt [6];

  // wait for the next done of instance i, returning cycles taken
  task automatic wait_done(input int i, input int d0, output int cyc);
    cyc = 0;
    while (done_cnt[i] == d0 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 2000) chk("done_timeout", 32'(cyc), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int i, r0, t0, d0, b0, cyc;
    i  = v.inst;
    r0 = rd_cnt[i];
    t0 = tx_cnt[i];
    d0 = done_cnt[i];
    b0 = busy_cnt[i];
    ack_dly[i] = v.ack;
    @(posedge clk); #1;
    start_s[i] = 1'b1;
    sadr_s[i]  = v.sadr;
    len_s[i]   = v.len;
    @(posedge clk); #1;
    start_s[i] = 1'b0;
    wait_done(i, d0, cyc);
    chk({v.nm, "_cycles"}, 32'(cyc), 32'(v.cyc));
    repeat (2) @(posedge clk);
    #1;
    chk({v.nm, "_done_cnt"}, 32'(done_cnt[i] - d0), 32'd1);
    chk({v.nm, "_busy_cycles"}, 32'(busy_cnt[i] - b0), 32'(v.cyc - 1));
    chk({v.nm, "_busy_after"}, 32'(busy_s[i]), 32'd0);
    chk({v.nm, "_reads"}, 32'(rd_cnt[i] - r0), 32'(v.n));
    chk({v.nm, "_bytes"}, 32'(tx_cnt[i] - t0), 32'(v.n));
    chk({v.nm, "_end_adr"}, 32'(adr_s[i]), 32'(v.end_adr));
    chk({v.nm, "_seq"}, 32'(seq_s[i]), 32'(v.seq));
    for (int k = 0; k < v.n && k < 3; k++) begin
      chk($sformatf("%s_rd_adr%0d", v.nm, k), 32'(rd_log[i][(r0 + k) % 64]), 32'(v.adr[k]));
      chk($sformatf("%s_byte%0d", v.nm, k), 32'(tx_log[i][(t0 + k) % 64]), 32'(v.b[k]));
    end
  endtask

  initial begin
    int r0, t0, d0, cyc;
    n_checks   = 0;
    n_errors   = 0;
    viol_cnt   = 0;
    glitch_cnt = 0;
    for (int i = 0; i < NI; i++) begin
      start_s[i]  = 1'b0;
      abort_s[i]  = 1'b0;
      sadr_s[i]   = 21'h0;
      len_s[i]    = 21'h0;
      ack_dly[i]  = 1;
      rd_cnt[i]   = 0;
      tx_cnt[i]   = 0;
      done_cnt[i] = 0;
      busy_cnt[i] = 0;
    end
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5C;
    mem[8'h10] = 8'hA1;
    mem[8'h11] = 8'hB2;
    mem[8'h12] = 8'hC3;

    //          nm      inst sadr        len     ack n  adr {2,1,0}                            bytes {2,1,0}           end_adr    seq   cyc
    vt[0] = '{"basic",  0, 21'h000010, 21'd3, 1,  3, {21'h000012, 21'h000011, 21'h000010}, {8'hC3, 8'hB2, 8'hA1}, 21'h000013, 1'b1, 19};
    vt[1] = '{"lat1",   1, 21'h000020, 21'd2, 1,  2, {21'h000000, 21'h000021, 21'h000020}, {8'h00, 8'h7D, 8'h7C}, 21'h000022, 1'b0, 11};
    vt[2] = '{"lat7",   2, 21'h000030, 21'd2, 1,  2, {21'h000000, 21'h000031, 21'h000030}, {8'h00, 8'h6D, 8'h6C}, 21'h000032, 1'b0, 23};
    vt[3] = '{"wrap",   0, 21'h1FFFFF, 21'd2, 1,  2, {21'h000000, 21'h000000, 21'h1FFFFF}, {8'h00, 8'h5C, 8'hA3}, 21'h000001, 1'b1, 13};
    vt[4] = '{"len0",   0, 21'h000077, 21'd0, 1,  0, {21'h000000, 21'h000000, 21'h000000}, {8'h00, 8'h00, 8'h00}, 21'h000001, 1'b1, 1};
    vt[5] = '{"bkpr",   0, 21'h000040, 21'd2, 50, 2, {21'h000000, 21'h000041, 21'h000040}, {8'h00, 8'h1D, 8'h1C}, 21'h000042, 1'b1, 111};

    // reset values
    rst_n = 1'b0;
    #2;
    chk("rst_adr",  32'(adr_s[0]),  32'd0);
    chk("rst_read", 32'(read_s[0]), 32'd0);
    chk("rst_dtx",  32'(dtx_s[0]),  32'd0);
    chk("rst_seq",  32'(seq_s[0]),  32'd0);
    chk("rst_busy", 32'(busy_s[0]), 32'd0);
    chk("rst_done", 32'(done_s[0]), 32'd0);
    #21;
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) run_vec(vt[v]);

    // abort during the second byte's WAIT; a start while busy must be ignored
    ack_dly[0] = 1;
    r0 = rd_cnt[0];
    t0 = tx_cnt[0];
    d0 = done_cnt[0];
    @(posedge clk); #1;
    start_s[0] = 1'b1;
    sadr_s[0]  = 21'h000050;
    len_s[0]   = 21'd10;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    cyc = 0;
    while (rd_cnt[0] < r0 + 2 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 200) chk("abort_wait_timeout", 32'(cyc), 32'd0);
    #1;
    abort_s[0] = 1'b1;
    start_s[0] = 1'b1;
    sadr_s[0]  = 21'h000070;
    len_s[0]   = 21'd5;
    @(posedge clk); #1;
    abort_s[0] = 1'b0;
    start_s[0] = 1'b0;
    wait_done(0, d0, cyc);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_reads", 32'(rd_cnt[0] - r0), 32'd2);
    chk("abort_bytes", 32'(tx_cnt[0] - t0), 32'd2);
    chk("abort_byte0", 32'(tx_log[0][t0 % 64]), 32'h0C);
    chk("abort_byte1", 32'(tx_log[0][(t0 + 1) % 64]), 32'h0D);
    chk("abort_done_cnt", 32'(done_cnt[0] - d0), 32'd1);
    chk("abort_end_adr", 32'(adr_s[0]), 32'h52);
    chk("abort_busy", 32'(busy_s[0]), 32'd0);

    // async reset in the middle of WAIT, off the clock edge
    r0 = rd_cnt[0];
    @(posedge clk); #1;
    start_s[0] = 1'b1;
    sadr_s[0]  = 21'h000060;
    len_s[0]   = 21'd4;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    cyc = 0;
    while (rd_cnt[0] < r0 + 1 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 200) chk("reset_wait_timeout", 32'(cyc), 32'd0);
    #3;
    chk("pre_rst_busy", 32'(busy_s[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_adr",  32'(adr_s[0]),  32'd0);
    chk("arst_read", 32'(read_s[0]), 32'd0);
    chk("arst_dtx",  32'(dtx_s[0]),  32'd0);
    chk("arst_seq",  32'(seq_s[0]),  32'd0);
    chk("arst_busy", 32'(busy_s[0]), 32'd0);
    chk("arst_done", 32'(done_s[0]), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    r0 = rd_cnt[0];
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_no_read", 32'(rd_cnt[0] - r0), 32'd0);
    chk("post_rst_idle", 32'(busy_s[0]), 32'd0);
    run_vec('{"after_rst", 0, 21'h000061, 21'd1, 1, 1, {21'h000000, 21'h000000, 21'h000061},
              {8'h00, 8'h00, 8'h3D}, 21'h000062, 1'b1, 7});

    chk("handshake_violations", 32'(viol_cnt), 32'd0);
    chk("data_tx_unstable", 32'(glitch_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
